// File: rtl/micro_sequencer.sv
// Next-state sequencer for the microcoded control unit: dispatch decode, memory wait
// insertion, illegal-dispatch trapping and a completed-instruction counter.
module micro_sequencer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [1:0]  ty,
  input  logic [4:0]  db_addr,
  input  logic [4:0]  bc_addr,
  input  logic        z,
  input  logic [15:0] ire,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic [4:0]  state,
  output logic        halted,
  output logic        stall,
  output logic [15:0] instr_count
);

  localparam logic [4:0] FETCH_STATE = 5'b00111;
  localparam logic [4:0] HALT_STATE  = 5'b11111;
  localparam logic [4:0] MAX_STATE   = 5'b10101;

  localparam logic [4:0] StAbdm1 = 5'b00000;
  localparam logic [4:0] StAdrm1 = 5'b00100;
  localparam logic [4:0] StBrzz1 = 5'b00101;
  localparam logic [4:0] StLdrm1 = 5'b01000;
  localparam logic [4:0] StStrm1 = 5'b01010;
  localparam logic [4:0] StTest1 = 5'b01011;
  localparam logic [4:0] StOprm1 = 5'b01100;
  localparam logic [4:0] StLdrr1 = 5'b01110;
  localparam logic [4:0] StStrr1 = 5'b01111;
  localparam logic [4:0] StPopr1 = 5'b10000;
  localparam logic [4:0] StPush1 = 5'b10010;
  localparam logic [4:0] StOprr1 = 5'b10100;

  localparam logic [1:0] TyIb = 2'b00;
  localparam logic [1:0] TySb = 2'b01;
  localparam logic [1:0] TyBc = 2'b10;
  localparam logic [1:0] TyDb = 2'b11;

  logic [4:0]  state_q;
  logic        halted_q;
  logic [15:0] count_q;

  logic [3:0]  opcode;
  logic [1:0]  mode;
  logic [4:0]  raw_target;
  logic [4:0]  next_state;
  logic        count_inc;

  assign opcode = ire[15:12];
  assign mode   = ire[5:4];

  // Raw dispatch target before the legality check.
  always_comb begin
    raw_target = HALT_STATE;
    case (ty)
      TyIb: begin
        case (opcode)
          4'd0, 4'd1, 4'd2, 4'd3: begin
            case (mode)
              2'b00:   raw_target = StAdrm1;
              2'b01:   raw_target = StAbdm1;
              default: raw_target = HALT_STATE;
            endcase
          end
          4'd4:    raw_target = StLdrr1;
          4'd5:    raw_target = StStrr1;
          4'd6:    raw_target = StPopr1;
          4'd7:    raw_target = StPush1;
          4'd8:    raw_target = StOprr1;
          4'd9:    raw_target = StBrzz1;
          default: raw_target = HALT_STATE;
        endcase
      end
      TySb: begin
        case (opcode)
          4'd0:    raw_target = StLdrm1;
          4'd1:    raw_target = StStrm1;
          4'd2:    raw_target = StOprm1;
          4'd3:    raw_target = StTest1;
          default: raw_target = HALT_STATE;
        endcase
      end
      TyBc:    raw_target = z ? bc_addr : db_addr;
      TyDb:    raw_target = db_addr;
      default: raw_target = HALT_STATE;
    endcase
  end

  // Anything above the last legal state (including 31 itself) traps.
  always_comb begin
    next_state = (raw_target > MAX_STATE) ? HALT_STATE : raw_target;
    count_inc  = (ty == TyIb) && (next_state != HALT_STATE);
  end

  assign stall = mem_req & ~mem_ack & ~halted_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= FETCH_STATE;
      halted_q <= 1'b0;
      count_q  <= 16'h0000;
    end else if (!halted_q && !stall) begin
      state_q  <= next_state;
      halted_q <= (next_state == HALT_STATE);
      if (count_inc) begin
        count_q <= count_q + 16'd1;
      end
    end
  end

  assign state       = state_q;
  assign halted      = halted_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: stimulus pushes expectations, a monitor checks them.
module tb_micro_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  ty = 2'b11;
  logic [4:0]  db_addr = 5'd0;
  logic [4:0]  bc_addr = 5'd0;
  logic        z = 1'b0;
  logic [15:0] ire = 16'h0;
  logic        mem_req = 1'b0;
  logic        mem_ack = 1'b0;
  logic [4:0]  state;
  logic        halted;
  logic        stall;
  logic [15:0] instr_count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    logic [4:0]  st;
    logic        h;
    logic [15:0] cnt;
    logic        stl;
    bit          chk;
  } exp_t;

  exp_t sb[$];

  micro_sequencer dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .ty          (ty),
    .db_addr     (db_addr),
    .bc_addr     (bc_addr),
    .z           (z),
    .ire         (ire),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .state       (state),
    .halted      (halted),
    .stall       (stall),
    .instr_count (instr_count)
  );

  always #5 clock = ~clock;

  // Monitor: one scoreboard entry per posedge, sampled 1ns after the edge.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.chk) begin
        tests++;
        if (state !== e.st || halted !== e.h || instr_count !== e.cnt || stall !== e.stl) begin
          fails++;
          $display("FAIL %s: got state=%b halted=%b count=%h stall=%b, want %b %b %h %b",
                   e.name, state, halted, instr_count, stall, e.st, e.h, e.cnt, e.stl);
        end
      end
    end
  end

  function automatic logic [15:0] mk_ire(input logic [3:0] op, input logic [1:0] md);
    return {op, 6'b000000, md, 4'b0000};
  endfunction

  task automatic cyc(input string nm, input logic [1:0] t, input logic [4:0] da,
                     input logic [4:0] ba, input logic zz, input logic [15:0] ir,
                     input logic rq, input logic ak, input logic [4:0] es, input logic eh,
                     input logic [15:0] ec, input logic esl, input bit chk);
    exp_t e;
    @(negedge clock);
    ty = t; db_addr = da; bc_addr = ba; z = zz; ire = ir; mem_req = rq; mem_ack = ak;
    e.name = nm; e.st = es; e.h = eh; e.cnt = ec; e.stl = esl; e.chk = chk;
    sb.push_back(e);
  endtask

  task automatic check_now(input string nm, input logic [4:0] es, input logic eh,
                           input logic [15:0] ec);
    tests++;
    if (state !== es || halted !== eh || instr_count !== ec) begin
      fails++;
      $display("FAIL %s: got state=%b halted=%b count=%h, want %b %b %h",
               nm, state, halted, instr_count, es, eh, ec);
    end
  endtask

  // Pulse reset between edges and check the asynchronous reset values.
  task automatic pulse_reset(input string nm);
    @(posedge clock);
    #3;
    mem_req = 1'b0;
    mem_ack = 1'b0;
    reset_n = 1'b0;
    #1;
    check_now(nm, 5'b00111, 1'b0, 16'h0000);
    reset_n = 1'b1;
  endtask

  logic [4:0] ib_states [6];
  initial begin
    ib_states[0] = 5'b01110; ib_states[1] = 5'b01111; ib_states[2] = 5'b10000;
    ib_states[3] = 5'b10010; ib_states[4] = 5'b10100; ib_states[5] = 5'b00101;
  end

  initial begin
    repeat (2) @(posedge clock);
    #3;
    check_now("reset_values", 5'b00111, 1'b0, 16'h0000);
    reset_n = 1'b1;

    cyc("fetch_db", 2'b11, 5'b00110, 5'd0, 1'b0, 16'h0, 1'b0, 1'b0,
        5'b00110, 1'b0, 16'd0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cyc($sformatf("ib_op%0d", i + 4), 2'b00, 5'd0, 5'd0, 1'b0, mk_ire(4'(i + 4), 2'b00),
          1'b0, 1'b0, ib_states[i], 1'b0, 16'(i + 1), 1'b0, 1'b1);
    end
    cyc("ib_op0_m01", 2'b00, 5'd0, 5'd0, 1'b0, mk_ire(4'd0, 2'b01), 1'b0, 1'b0,
        5'b00000, 1'b0, 16'd7, 1'b0, 1'b1);
    cyc("ib_op0_m00", 2'b00, 5'd0, 5'd0, 1'b0, mk_ire(4'd0, 2'b00), 1'b0, 1'b0,
        5'b00100, 1'b0, 16'd8, 1'b0, 1'b1);
    cyc("sb_op2", 2'b01, 5'd0, 5'd0, 1'b0, mk_ire(4'd2, 2'b00), 1'b0, 1'b0,
        5'b01100, 1'b0, 16'd8, 1'b0, 1'b1);
    cyc("bc_taken", 2'b10, 5'b00111, 5'b00110, 1'b1, 16'h0, 1'b0, 1'b0,
        5'b00110, 1'b0, 16'd8, 1'b0, 1'b1);
    cyc("bc_not_taken", 2'b10, 5'b00111, 5'b00110, 1'b0, 16'h0, 1'b0, 1'b0,
        5'b00111, 1'b0, 16'd8, 1'b0, 1'b1);
    cyc("ack_without_req", 2'b11, 5'b00011, 5'd0, 1'b0, 16'h0, 1'b0, 1'b1,
        5'b00011, 1'b0, 16'd8, 1'b0, 1'b1);

    // Memory wait: an IB held off by three wait cycles must not count until it completes.
    for (int i = 0; i < 3; i++) begin
      cyc($sformatf("mem_wait%0d", i), 2'b00, 5'd0, 5'd0, 1'b0, mk_ire(4'd4, 2'b00),
          1'b1, 1'b0, 5'b00011, 1'b0, 16'd8, 1'b1, 1'b1);
    end
    cyc("mem_ack", 2'b00, 5'd0, 5'd0, 1'b0, mk_ire(4'd4, 2'b00), 1'b1, 1'b1,
        5'b01110, 1'b0, 16'd9, 1'b0, 1'b1);

    cyc("ib_illegal_op", 2'b00, 5'd0, 5'd0, 1'b0, mk_ire(4'hC, 2'b00), 1'b0, 1'b0,
        5'b11111, 1'b1, 16'd9, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc($sformatf("halt_hold%0d", i), 2'b11, 5'd0, 5'd0, 1'b0, mk_ire(4'd4, 2'b00),
          1'(i % 2), 1'b0, 5'b11111, 1'b1, 16'd9, 1'b0, 1'b1);
    end
    pulse_reset("reset_from_halt");

    cyc("db_25", 2'b11, 5'd25, 5'd0, 1'b0, 16'h0, 1'b0, 1'b0,
        5'b11111, 1'b1, 16'd0, 1'b0, 1'b1);
    pulse_reset("reset_after_db25");
    cyc("db_21_legal", 2'b11, 5'd21, 5'd0, 1'b0, 16'h0, 1'b0, 1'b0,
        5'd21, 1'b0, 16'd0, 1'b0, 1'b1);
    cyc("bc_31", 2'b10, 5'd1, 5'd31, 1'b1, 16'h0, 1'b0, 1'b0,
        5'b11111, 1'b1, 16'd0, 1'b0, 1'b1);
    pulse_reset("reset_after_bc31");
    cyc("db_22", 2'b11, 5'd22, 5'd0, 1'b0, 16'h0, 1'b0, 1'b0,
        5'b11111, 1'b1, 16'd0, 1'b0, 1'b1);
    pulse_reset("reset_after_db22");
    cyc("sb_illegal", 2'b01, 5'd0, 5'd0, 1'b0, mk_ire(4'd5, 2'b00), 1'b0, 1'b0,
        5'b11111, 1'b1, 16'd0, 1'b0, 1'b1);
    pulse_reset("reset_after_sb");
    cyc("ib_op1_m10", 2'b00, 5'd0, 5'd0, 1'b0, mk_ire(4'd1, 2'b10), 1'b0, 1'b0,
        5'b11111, 1'b1, 16'd0, 1'b0, 1'b1);
    pulse_reset("reset_after_mode10");

    cyc("ib_op8", 2'b00, 5'd0, 5'd0, 1'b0, mk_ire(4'd8, 2'b00), 1'b0, 1'b0,
        5'b10100, 1'b0, 16'd1, 1'b0, 1'b1);
    cyc("stall_before_reset", 2'b11, 5'd2, 5'd0, 1'b0, 16'h0, 1'b1, 1'b0,
        5'b10100, 1'b0, 16'd1, 1'b1, 1'b1);
    pulse_reset("reset_mid_stall");

    // Counter wrap: 65535 IB dispatches reach FFFF, one more wraps to 0.
    for (int i = 1; i <= 65535; i++) begin
      cyc("wrap_ffff", 2'b00, 5'd0, 5'd0, 1'b0, mk_ire(4'd4, 2'b00), 1'b0, 1'b0,
          5'b01110, 1'b0, 16'(i), 1'b0, (i == 65535));
    end
    cyc("wrap_0000", 2'b00, 5'd0, 5'd0, 1'b0, mk_ire(4'd4, 2'b00), 1'b0, 1'b0,
        5'b01110, 1'b0, 16'h0000, 1'b0, 1'b1);

    @(posedge clock);
    #3;
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
